// File: rtl/vend_fsm_multi.sv
// ----------------------------------------------------------------------------
// vend_fsm_multi
//   Multi-product vending controller. Accumulates coin credit up to
//   CREDIT_MAX, vends one of NUM_ITEMS products when a one-hot select is
//   affordable, and pays back any remaining credit (or the whole credit on
//   cancel) one coin unit per cycle.
//
// Parameters
//   NUM_ITEMS   number of selectable products (1..8)
//   CW          credit/price width in bits
//   CREDIT_MAX  maximum credit in coin units
//   PRICES      packed prices, price of item i = PRICES[i*CW +: CW], each >= 1
//
// Ports
//   clk         rising-edge system clock
//   rst_n       synchronous active-low reset
//   i_coin      one-cycle pulse, insert one coin unit
//   i_sel       one-cycle product select, one-hot
//   i_cancel    one-cycle pulse, refund all credit
//   o_led       item i affordable while accepting input (combinational)
//   o_vend      one-cycle dispense pulse for item i (registered)
//   o_change    one-cycle pulse per returned coin unit (registered)
//   o_coin_rej  one-cycle pulse, coin not accepted (registered)
//   o_busy      high while vending or paying back change (registered)
//   o_credit    current credit (registered)
//   o_bcd       {tens, ones} BCD of o_credit (combinational)
// ----------------------------------------------------------------------------
module vend_fsm_multi #(
  parameter int                          NUM_ITEMS  = 2,
  parameter int                          CW         = 4,
  parameter int                          CREDIT_MAX = 9,
  parameter logic [NUM_ITEMS*CW-1:0]     PRICES     = {4'd3, 4'd2}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_coin,
  input  logic [NUM_ITEMS-1:0] i_sel,
  input  logic                 i_cancel,
  output logic [NUM_ITEMS-1:0] o_led,
  output logic [NUM_ITEMS-1:0] o_vend,
  output logic                 o_change,
  output logic                 o_coin_rej,
  output logic                 o_busy,
  output logic [CW-1:0]        o_credit,
  output logic [7:0]           o_bcd
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  localparam logic [CW-1:0] CREDIT_MAX_C = CW'(CREDIT_MAX);
  localparam logic [CW-1:0] ONE_C        = CW'(1);
  localparam logic [CW-1:0] ZERO_C       = CW'(0);

  state_t                 state_r;
  logic [CW-1:0]          credit_r;
  logic [CW-1:0]          sel_price_s;
  logic                   sel_onehot_s;
  logic                   sel_valid_s;
  logic                   accepting_s;
  logic [NUM_ITEMS-1:0]   led_s;

  // Binary credit to two BCD digits; credit never exceeds 99.
  function automatic logic [7:0] to_bcd(input logic [CW-1:0] value);
    logic [31:0] wide;
    logic [3:0]  tens;
    logic [3:0]  ones;
    wide = 32'(value);
    tens = 4'(wide / 32'd10);
    ones = 4'(wide % 32'd10);
    return {tens, ones};
  endfunction

  assign accepting_s  = (state_r == ST_IDLE) || (state_r == ST_CREDIT);
  assign sel_onehot_s = $onehot(i_sel);

  // Price of the selected item; only meaningful when the select is one-hot.
  always_comb begin
    sel_price_s = ZERO_C;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      sel_price_s = i_sel[i] ? PRICES[i*CW +: CW] : sel_price_s;
    end
  end

  assign sel_valid_s = sel_onehot_s && (credit_r >= sel_price_s);

  // Affordability LEDs, suppressed while vending or paying change.
  always_comb begin
    led_s = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      led_s[i] = accepting_s ? (credit_r >= PRICES[i*CW +: CW]) : 1'b0;
    end
  end

  assign o_led    = led_s;
  assign o_credit = credit_r;
  assign o_bcd    = to_bcd(credit_r);

  // Main controller: state, credit and all registered pulse outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      credit_r   <= ZERO_C;
      o_vend     <= '0;
      o_change   <= 1'b0;
      o_coin_rej <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_vend     <= '0;
      o_change   <= 1'b0;
      o_coin_rej <= 1'b0;
      case (state_r)
        ST_IDLE, ST_CREDIT: begin
          if (i_cancel) begin
            // A coin arriving with cancel is never banked.
            o_coin_rej <= i_coin;
            if (credit_r != ZERO_C) begin
              state_r <= ST_CHANGE;
              o_busy  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              o_busy  <= 1'b0;
            end
          end else if (sel_valid_s) begin
            o_coin_rej <= i_coin;
            credit_r   <= credit_r - sel_price_s;
            o_vend     <= i_sel;
            state_r    <= ST_VEND;
            o_busy     <= 1'b1;
          end else if (i_coin) begin
            if (credit_r < CREDIT_MAX_C) begin
              credit_r <= credit_r + ONE_C;
              state_r  <= ST_CREDIT;
            end else begin
              o_coin_rej <= 1'b1;
            end
          end else begin
            state_r <= state_r;
          end
        end
        ST_VEND: begin
          o_coin_rej <= i_coin;
          if (credit_r != ZERO_C) begin
            state_r <= ST_CHANGE;
            o_busy  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            o_busy  <= 1'b0;
          end
        end
        ST_CHANGE: begin
          o_coin_rej <= i_coin;
          if (credit_r != ZERO_C) begin
            o_change <= 1'b1;
            credit_r <= credit_r - ONE_C;
            // Leave on the same edge that pays out the last unit.
            if (credit_r == ONE_C) begin
              state_r <= ST_IDLE;
              o_busy  <= 1'b0;
            end else begin
              state_r <= ST_CHANGE;
              o_busy  <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          credit_r <= ZERO_C;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_fsm_multi.sv
// ----------------------------------------------------------------------------
// tb_vend_fsm_multi
//   Directed stimulus for vend_fsm_multi (2 items, prices 2 and 3, max 9).
//   A schedule-based reference model predicts every output each cycle; a few
//   literal expectations pin the scenarios independently of that model.
// ----------------------------------------------------------------------------
module tb_vend_fsm_multi;

  localparam int NI   = 2;
  localparam int CWB  = 4;
  localparam int CMAX = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          coin;
  logic [NI-1:0] sel;
  logic          cancel;
  logic [NI-1:0] led;
  logic [NI-1:0] vend;
  logic          change;
  logic          coin_rej;
  logic          busy;
  logic [CWB-1:0] credit;
  logic [7:0]    bcd;

  int checks   = 0;
  int failures = 0;

  vend_fsm_multi #(
    .NUM_ITEMS (NI),
    .CW        (CWB),
    .CREDIT_MAX(CMAX),
    .PRICES    ({4'd3, 4'd2})
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_coin    (coin),
    .i_sel     (sel),
    .i_cancel  (cancel),
    .o_led     (led),
    .o_vend    (vend),
    .o_change  (change),
    .o_coin_rej(coin_rej),
    .o_busy    (busy),
    .o_credit  (credit),
    .o_bcd     (bcd)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Upcoming output cycles once a vend or refund has been committed.
  typedef struct {
    logic [NI-1:0] v;
    logic          ch;
    logic          b;
    int            cr;
  } step_t;

  step_t         plan[$];
  int            price[NI] = '{2, 3};
  bit            mvalid = 1'b0;
  int            m_credit;
  logic [NI-1:0] m_vend;
  logic          m_change;
  logic          m_rej;
  logic          m_busy;

  function automatic step_t mk(input logic [NI-1:0] v, input logic ch,
                               input logic b, input int cr);
    step_t s;
    s.v = v; s.ch = ch; s.b = b; s.cr = cr;
    return s;
  endfunction

  // Pay back n units: one quiet busy cycle, then n pulses; the last pulse
  // is shown while the machine is already free again.
  task automatic plan_refund(input int n);
    plan.push_back(mk('0, 1'b0, 1'b1, n));
    for (int k = 1; k <= n; k++) plan.push_back(mk('0, 1'b1, (k < n), n - k));
  endtask

  task automatic take_step();
    step_t s;
    s = plan.pop_front();
    m_vend = s.v; m_change = s.ch; m_busy = s.b; m_credit = s.cr;
  endtask

  // Compare current outputs, then advance the model with the inputs the
  // next rising edge will sample.
  always @(negedge clk) begin
    logic [NI-1:0] e_led;
    logic [7:0]    e_bcd;
    int            idx;
    if (mvalid) begin
      for (int i = 0; i < NI; i++) e_led[i] = !m_busy && (m_credit >= price[i]);
      e_bcd = {4'(m_credit / 10), 4'(m_credit % 10)};
      checks++;
      if (vend !== m_vend || change !== m_change || coin_rej !== m_rej ||
          busy !== m_busy || credit !== 4'(m_credit) || bcd !== e_bcd || led !== e_led) begin
        failures++;
        $display("FAIL model t=%0t got vend=%b chg=%b rej=%b busy=%b cr=%0d bcd=%h led=%b exp vend=%b chg=%b rej=%b busy=%b cr=%0d bcd=%h led=%b",
                 $time, vend, change, coin_rej, busy, credit, bcd, led,
                 m_vend, m_change, m_rej, m_busy, m_credit, e_bcd, e_led);
      end
    end
    if (!rst_n) begin
      plan.delete();
      m_credit = 0; m_vend = '0; m_change = 1'b0; m_rej = 1'b0; m_busy = 1'b0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      m_rej = 1'b0;
      if (plan.size() > 0) begin
        m_rej = coin;
        take_step();
      end else begin
        m_vend = '0; m_change = 1'b0; m_busy = 1'b0;
        idx = 0;
        for (int i = 0; i < NI; i++) if (sel[i]) idx = i;
        if (cancel) begin
          m_rej = coin;
          if (m_credit > 0) begin
            plan_refund(m_credit);
            take_step();
          end
        end else if ($countones(sel) == 1 && m_credit >= price[idx]) begin
          m_rej = coin;
          plan.push_back(mk(sel, 1'b0, 1'b1, m_credit - price[idx]));
          if (m_credit - price[idx] > 0) plan_refund(m_credit - price[idx]);
          else plan.push_back(mk('0, 1'b0, 1'b0, 0));
          take_step();
        end else if (coin) begin
          if (m_credit < CMAX) m_credit++;
          else m_rej = 1'b1;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [NI-1:0] s, input logic k);
    coin = c; sel = s; cancel = k;
    @(posedge clk); #1;
    coin = 1'b0; sel = '0; cancel = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
  endtask

  task automatic coins(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, '0, 1'b0);
  endtask

  int n_chg;
  int n_rej;

  initial begin
    rst_n = 1'b0; coin = 1'b0; sel = '0; cancel = 1'b0;
    @(posedge clk); #1;
    idle(2);
    chk("reset_credit", int'(credit), 0);
    chk("reset_bcd", int'(bcd), 0);
    chk("reset_led", int'(led), 0);
    chk("reset_busy", int'(busy), 0);
    rst_n = 1'b1;

    // 1: exact payment for item 1
    coins(3);
    chk("t1_credit", int'(credit), 3);
    chk("t1_led", int'(led), 3);
    drive(1'b0, 2'b10, 1'b0);
    chk("t1_vend", int'(vend), 2);
    chk("t1_busy", int'(busy), 1);
    idle(1);
    chk("t1_vend_off", int'(vend), 0);
    chk("t1_nochange", int'(change), 0);
    chk("t1_bcd", int'(bcd), 8'h00);
    chk("t1_idle", int'(busy), 0);

    // 2: overpayment returns three units
    coins(5);
    drive(1'b0, 2'b01, 1'b0);
    chk("t2_vend", int'(vend), 1);
    chk("t2_credit", int'(credit), 3);
    n_chg = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (change) n_chg++;
    end
    chk("t2_pulses", n_chg, 3);
    chk("t2_credit_end", int'(credit), 0);

    // 3: saturate at nine, tenth coin rejected
    coins(9);
    chk("t3_credit", int'(credit), 9);
    chk("t3_bcd", int'(bcd), 8'h09);
    drive(1'b1, '0, 1'b0);
    chk("t3_rej", int'(coin_rej), 1);
    chk("t3_credit_hold", int'(credit), 9);
    drive(1'b0, '0, 1'b1);
    idle(12);
    chk("t3_refund_done", int'(credit), 0);

    // 4: unaffordable and multi-hot selects are ignored
    coins(1);
    drive(1'b0, 2'b10, 1'b0);
    chk("t4_novend", int'(vend), 0);
    chk("t4_credit", int'(credit), 1);
    coins(2);
    drive(1'b0, 2'b11, 1'b0);
    chk("t4_multi_novend", int'(vend), 0);
    chk("t4_multi_credit", int'(credit), 3);
    chk("t4_multi_busy", int'(busy), 0);
    drive(1'b0, '0, 1'b1);
    idle(6);

    // 5: cancel beats select and coin
    coins(4);
    drive(1'b1, 2'b01, 1'b1);
    chk("t5_rej", int'(coin_rej), 1);
    chk("t5_novend", int'(vend), 0);
    chk("t5_busy", int'(busy), 1);
    n_chg = 0; n_rej = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (change) n_chg++;
      if (coin_rej) n_rej++;
      if (vend != '0) n_rej += 100;
    end
    chk("t5_pulses", n_chg, 4);
    chk("t5_no_more_rej_or_vend", n_rej, 0);

    // 6: reset in the middle of paying change
    coins(3);
    drive(1'b0, '0, 1'b1);
    idle(1);
    chk("t6_first_pulse", int'(change), 1);
    chk("t6_credit_mid", int'(credit), 2);
    rst_n = 1'b0;
    idle(1);
    chk("t6_credit", int'(credit), 0);
    chk("t6_change", int'(change), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_led", int'(led), 0);
    rst_n = 1'b1;
    n_chg = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (change) n_chg++;
    end
    chk("t6_discarded", n_chg, 0);

    idle(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
